// File: rtl/mul4_seq.sv
// mul4_seq: 4x4 unsigned sequential shift-add multiplier with fa4bit partial-product adder
module fa4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  assign cout = c[4];
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
endmodule

module mul4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t     state;
  logic [3:0] mcand;
  logic [8:0] acc;
  logic [1:0] cnt;
  logic [3:0] sum;
  logic       carry;
  // acc[8] is held at zero, so the adder carry-in is effectively 0
  fa4bit u_fa (
    .x   (acc[7:4]),
    .y   (mcand & {4{acc[0]}}),
    .cin (acc[8]),
    .s   (sum),
    .cout(carry)
  );
  // control FSM and datapath: accept in IDLE/DONE, four shift-add steps in CALC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else if (state == CALC) begin
      acc <= {1'b0, carry, sum, acc[3:1]};
      cnt <= cnt + 2'd1;
      if (cnt == 2'd3) begin
        state   <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        product <= {carry, sum, acc[3:1]};
      end
    end else if (start) begin
      state <= CALC;
      mcand <= a;
      acc   <= {5'b0, b};
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mul4_seq.sv
// tb_mul4_seq: randomized scoreboard bench for mul4_seq against an a*b reference
module tb_mul4_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] product;
  int         vecs = 0;
  int         errs = 0;
  int         q[$];
  int         last_exp = 0;
  bit         prev_done = 0;

  mul4_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on each done, checks hold, pulse width and reset values
  always @(negedge clk) begin
    if (!rst_n) begin
      last_exp = 0;
      prev_done = 0;
      check("rst_product", int'(product), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
    end else begin
      check("busy_done_overlap", int'(busy & done), 0);
      if (done) begin
        check("done_width", int'(prev_done), 0);
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          last_exp = q.pop_front();
          check("product", int'(product), last_exp);
        end
      end else check("product_hold", int'(product), last_exp);
      prev_done = done;
    end
  end

  task automatic op(input logic [3:0] x, input logic [3:0] y, input int pulse);
    int n, nb;
    bit got;
    n = 0; nb = 0; got = 0;
    @(posedge clk); #1;
    start = 1; a = x; b = y;
    q.push_back(int'(x) * int'(y));
    @(posedge clk); #1;
    start = 0; a = 4'($urandom); b = 4'($urandom);
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (done) got = 1;
      if (pulse > 0 && n == pulse) begin start = 1; a = 4'd15; b = 4'd15; end
      if (pulse > 0 && n == pulse + 1) start = 0;
    end
    check("latency", n, 5);
    check("busy_cycles", nb, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, n1, n2, nd;
    bit idle_seen;
    repeat (3) @(negedge clk);
    #1;
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    check("init_product", int'(product), 0);
    @(negedge clk); #2 rst_n = 1;
    op(4'd10, 4'd5, 0);
    op(4'd0, 4'd15, 0);
    op(4'd15, 4'd15, 0);
    op(4'd1, 4'd1, 0);
    op(4'd3, 4'd3, 2);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("extra_done", nd, 0);
    @(posedge clk); #1;
    start = 1; a = 4'd2; b = 4'd7;
    q.push_back(14);
    @(posedge clk); #1;
    a = 4'd9; b = 4'd6;
    q.push_back(54);
    n = 0; n1 = 0; n2 = 0; idle_seen = 0;
    while (n2 == 0 && n < 15) begin
      @(negedge clk);
      n++;
      if (n1 > 0 && !done && !busy) idle_seen = 1;
      if (done && n1 == 0) n1 = n;
      else if (done) begin n2 = n; start = 0; end
    end
    start = 0;
    check("b2b_first", n1, 5);
    check("b2b_second", n2, 10);
    check("b2b_idle", int'(idle_seen), 0);
    @(posedge clk); #1;
    start = 1; a = 4'd12; b = 4'd12;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_product", int'(product), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    op(4'd12, 4'd12, 0);
    repeat (30) op(4'($urandom), 4'($urandom), 0);
    for (int i = 0; i < 256; i++) op(4'(i >> 4), 4'(i), 0);
    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
